apb_uart_tx_scheduler: RTL
==========================

Name: apb_uart_tx_scheduler

Overview:
- APB master sitting in front of the UART APB bridge: programs the bridge's enable and control registers after reset, then shares the UART transmitter between NREQ byte requesters using round-robin arbitration.
- Each granted byte is issued as one APB write to the TX data register (0x0C). The grant is held until the UART reports tx done, or until a timeout.
- Requester-side handshake is a req/ack pair per requester.

Parameters:
- NREQ, 4, number of byte requesters (2..8).
- TIMEOUT, 65535, max PCLK cycles to wait for tx_done_flag per byte.
- RST_PARITY, 2'b00, parity_type programmed at init.
- RST_BAUD, 2'b00, baud_rate programmed at init.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester byte-pending; held high until matching ack.
- req_data  in  8*NREQ  byte for requester i at [8i+7:8i]; stable while req[i]=1.
- cfg_valid  in  1  pulse: request reprogramming of control reg.
- cfg_parity  in  2  new parity, sampled when cfg_valid=1.
- cfg_baud  in  2  new baud, sampled when cfg_valid=1.
- ack  out  NREQ  one-cycle pulse on bit i when requester i's byte is finished.
- err  out  1  one-cycle pulse coincident with ack when the byte timed out.
- grant  out  NREQ  one-hot owner of the transmitter; 0 when idle.
- busy  out  1  high in every state except IDLE.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR  out  5  APB address.
- PWDATA  out  32  APB write data.
- PREADY  in  1  APB slave ready.
- tx_done_flag  in  1  UART tx done.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = INIT_EN_SETUP.
  - rr_ptr = NREQ-1, so requester 0 wins first.
  - Latched cfg = {RST_BAUD, RST_PARITY}.
  - cfg_pending = 0; timeout counter = 0.
- APB write sequence (every write):
  - SETUP cycle: PSEL=1, PENABLE=0, PWRITE=1; PADDR and PWDATA valid.
  - ACCESS cycle(s): PSEL=1, PENABLE=1; hold until PREADY=1 is sampled.
  - Next cycle: PSEL=PENABLE=PWRITE=0; PADDR and PWDATA return to 0.
  - Never issues reads.
- FSM states and transitions:
  - INIT_EN_SETUP -> INIT_EN_ACCESS: writes 0x00 with PWDATA=32'h3 (rx and tx enable).
  - INIT_EN_ACCESS -> INIT_CTRL_SETUP on PREADY.
  - INIT_CTRL_SETUP -> INIT_CTRL_ACCESS: writes 0x04 with PWDATA={28'b0, baud, parity} from the latched cfg.
  - INIT_CTRL_ACCESS -> IDLE on PREADY; clears cfg_pending.
  - IDLE:
    - if cfg_pending -> INIT_CTRL_SETUP (config has priority over bytes);
    - else if |req -> ARB;
    - else stay.
  - ARB (1 cycle):
    - winner = first set req bit searching rr_ptr+1 upward, wrapping mod NREQ;
    - grant <= onehot(winner); latch req_data byte; rr_ptr <= winner.
    - -> TX_SETUP.
  - TX_SETUP -> TX_ACCESS: writes 0x0C with PWDATA={24'b0, byte}.
  - TX_ACCESS -> TX_WAIT on PREADY; timeout counter cleared.
  - TX_WAIT:
    - if tx_done_flag=1: ack[winner]=1 for 1 cycle, grant<=0, -> IDLE.
    - else if counter==TIMEOUT-1: ack[winner]=1 and err=1 for 1 cycle, grant<=0, -> IDLE.
    - else counter++.
- cfg_valid:
  - Accepted in any state; latches cfg_parity/cfg_baud and sets cfg_pending.
  - A second cfg_valid before the write overwrites the latched value; only the last one is written.
  - A byte already in flight is not disturbed.
- Latency: idle with req[i] rising -> ARB next cycle -> TX_SETUP -> TX_ACCESS. The minimum from req to PWRITE access is 3 cycles.
- ack timing: ack is asserted in the cycle tx_done_flag is sampled high in TX_WAIT. tx_done_flag seen in any other state is ignored.
- Requester protocol:
  - A requester may drop req only after its ack.
  - A req bit dropping while not granted is simply not served.
  - The granted byte is already latched, so dropping req after grant has no effect.
- Fairness: after a requester is served, every other pending requester is served before it is served again.
- Reset mid-operation: PRESET asserted in any state forces reset values immediately, including PSEL=0. Init is always redone after reset.

Test Plan:
- Reset release, PREADY tied 1, RST_PARITY=2'b01, RST_BAUD=2'b10 -> write 0x00/0x3, then 0x04/0x9, each SETUP+ACCESS; then IDLE with busy=0.
- req=4'b0001, data0=8'hA5, tx_done_flag pulsed 5 cycles after access -> one write 0x0C/0xA5; ack=4'b0001 for exactly 1 cycle with the done pulse; err=0.
- req=4'b1111 held, each requester reasserting after its ack -> grant order 0,1,2,3,0; PREADY held low for 2 cycles on one access -> ACCESS stretched, PSEL/PENABLE held.
- cfg_valid (parity=2'b11, baud=2'b01) pulsed during TX_WAIT with req1 also pending -> current byte completes, then write 0x04/0x7, then req1's byte.
- TIMEOUT=16, tx_done_flag never asserted -> ack and err pulse together 16 cycles after the access completes; grant=0; the next requester is then served.
- PRESET pulsed during TX_ACCESS -> all outputs 0 at once; after release the full init sequence repeats and requester 0 has priority.

Source files
------------

// File: rtl/apb_uart_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// apb_uart_tx_scheduler_if
// Bundles the requester handshake, config request, status outputs, the APB
// master bus toward the UART bridge and the UART tx-done indication.
//   master : view of the scheduler (drives ack/err/grant/busy and APB controls)
//   slave  : view of the environment (requesters, APB slave, UART)
// Ports: req, req_data, cfg_valid, cfg_parity, cfg_baud, ack, err, grant,
//        busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY, tx_done_flag.
// ----------------------------------------------------------------------------
interface apb_uart_tx_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic              cfg_valid;
    logic [1:0]        cfg_parity;
    logic [1:0]        cfg_baud;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [4:0]        PADDR;
    logic [31:0]       PWDATA;
    logic              PREADY;
    logic              tx_done_flag;

    modport master (
        input  req, req_data, cfg_valid, cfg_parity, cfg_baud, PREADY, tx_done_flag,
        output ack, err, grant, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req, req_data, cfg_valid, cfg_parity, cfg_baud, PREADY, tx_done_flag,
        input  ack, err, grant, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// apb_uart_tx_scheduler
// APB master in front of the UART APB bridge. After reset it writes the
// enable register (0x00 <- 3) and the control register (0x04 <- {baud,parity}),
// then shares the transmitter among NREQ byte requesters round-robin. Each
// granted byte becomes one APB write to 0x0C; the grant is held until the UART
// reports tx_done_flag or TIMEOUT cycles pass.
// Ports:
//   PCLK   : clock, rising edge
//   PRESET : asynchronous active-high reset
//   bus    : apb_uart_tx_scheduler_if.master (requesters, config, APB, UART)
// ----------------------------------------------------------------------------
module apb_uart_tx_scheduler #(
    parameter int         NREQ       = 4,
    parameter int         TIMEOUT    = 65535,
    parameter logic [1:0] RST_PARITY = 2'b00,
    parameter logic [1:0] RST_BAUD   = 2'b00
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    apb_uart_tx_scheduler_if.master         bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [3:0] INIT_EN_SETUP    = 4'd0;
    localparam logic [3:0] INIT_EN_ACCESS   = 4'd1;
    localparam logic [3:0] INIT_CTRL_SETUP  = 4'd2;
    localparam logic [3:0] INIT_CTRL_ACCESS = 4'd3;
    localparam logic [3:0] IDLE             = 4'd4;
    localparam logic [3:0] ARB              = 4'd5;
    localparam logic [3:0] TX_SETUP         = 4'd6;
    localparam logic [3:0] TX_ACCESS        = 4'd7;
    localparam logic [3:0] TX_WAIT          = 4'd8;

    logic [3:0]      state, state_d;
    logic            out_en;       // low only in the first cycle after reset, keeps outputs at 0
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant_q;
    logic [3:0]      cfg_lat;      // {baud, parity}
    logic            cfg_pending;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      wr_byte;      // payload of the current control or TX write
    logic [PW-1:0]   winner;
    logic [7:0]      win_byte;
    logic            psel_c, penable_c, tx_done_now, tx_tmo_now;

    // First set bit strictly after ptr, wrapping; ptr itself has lowest priority.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx_v;
        int            idx;
        pick = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx   = (int'(ptr) + k) % NREQ;
            idx_v = idx[PW-1:0];
            if (r[idx_v]) pick = idx_v;
        end
        return pick;
    endfunction

    assign winner = rr_pick(bus.req, rr_ptr);

    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PW'(i)) win_byte = bus.req_data[8*i +: 8];
        end
    end

    always_comb begin
        psel_c      = out_en && (state == INIT_EN_SETUP || state == INIT_CTRL_SETUP ||
                                 state == TX_SETUP || state == INIT_EN_ACCESS ||
                                 state == INIT_CTRL_ACCESS || state == TX_ACCESS);
        penable_c   = (state == INIT_EN_ACCESS || state == INIT_CTRL_ACCESS || state == TX_ACCESS);
        tx_done_now = (state == TX_WAIT) && bus.tx_done_flag;
        tx_tmo_now  = (state == TX_WAIT) && !bus.tx_done_flag && (tmo_cnt == TW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d = state;
        case (state)
            INIT_EN_SETUP:    if (out_en) state_d = INIT_EN_ACCESS;
            INIT_EN_ACCESS:   if (bus.PREADY) state_d = INIT_CTRL_SETUP;
            INIT_CTRL_SETUP:  state_d = INIT_CTRL_ACCESS;
            INIT_CTRL_ACCESS: if (bus.PREADY) state_d = IDLE;
            IDLE: begin
                if (cfg_pending)   state_d = INIT_CTRL_SETUP;
                else if (|bus.req) state_d = ARB;
            end
            // A request withdrawn before arbitration is simply not served.
            ARB:              state_d = (|bus.req) ? TX_SETUP : IDLE;
            TX_SETUP:         state_d = TX_ACCESS;
            TX_ACCESS:        if (bus.PREADY) state_d = TX_WAIT;
            TX_WAIT:          if (tx_done_now || tx_tmo_now) state_d = IDLE;
            default:          state_d = INIT_EN_SETUP;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= INIT_EN_SETUP;
            out_en      <= 1'b0;
            rr_ptr      <= PW'(NREQ - 1);
            grant_q     <= '0;
            cfg_lat     <= {RST_BAUD, RST_PARITY};
            cfg_pending <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state  <= state_d;
            out_en <= 1'b1;
            if (bus.cfg_valid) begin
                cfg_lat     <= {bus.cfg_baud, bus.cfg_parity};
                cfg_pending <= 1'b1;
            // A cfg update that lands during the control write leaves the
            // latched value different from the one written, so keep pending.
            end else if (state == INIT_CTRL_ACCESS && bus.PREADY && wr_byte[3:0] == cfg_lat) begin
                cfg_pending <= 1'b0;
            end
            if (state == ARB && |bus.req) begin
                grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                rr_ptr  <= winner;
            end else if (tx_done_now || tx_tmo_now) begin
                grant_q <= '0;
            end
            if (state == TX_ACCESS)    tmo_cnt <= '0;
            else if (state == TX_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Write payload is snapshotted on entry so PWDATA stays stable for the whole transfer.
    always_ff @(posedge PCLK) begin
        if (state_d == INIT_CTRL_SETUP) wr_byte <= {4'b0000, cfg_lat};
        else if (state == ARB)          wr_byte <= win_byte;
    end

    always_comb begin
        bus.PADDR  = 5'h00;
        bus.PWDATA = 32'h0;
        if (psel_c) begin
            case (state)
                INIT_EN_SETUP, INIT_EN_ACCESS: begin
                    bus.PADDR  = 5'h00;
                    bus.PWDATA = 32'h3;
                end
                INIT_CTRL_SETUP, INIT_CTRL_ACCESS: begin
                    bus.PADDR  = 5'h04;
                    bus.PWDATA = {28'h0, wr_byte[3:0]};
                end
                TX_SETUP, TX_ACCESS: begin
                    bus.PADDR  = 5'h0C;
                    bus.PWDATA = {24'h0, wr_byte};
                end
                default: begin
                    bus.PADDR  = 5'h00;
                    bus.PWDATA = 32'h0;
                end
            endcase
        end
    end

    assign bus.PSEL    = psel_c;
    assign bus.PENABLE = penable_c;
    assign bus.PWRITE  = psel_c;
    assign bus.grant   = grant_q;
    assign bus.busy    = out_en && (state != IDLE);
    assign bus.ack     = (tx_done_now || tx_tmo_now) ? grant_q : '0;
    assign bus.err     = tx_tmo_now;

endmodule
